vlsu_axi_mem_sub: RTL and testbench

//  AXI4 subordinate memory model that answers the VLSU control machine's AW/AR requests: accepts

---
 rtl/vlsu_axi_mem_sub.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_vlsu_axi_mem_sub.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_axi_mem_sub.sv
// AXI4 subordinate memory model for the VLSU master port.
// Independent read/write FSMs, one outstanding burst per direction.
package vlsu_axi_mem_sub_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 128;
  localparam int unsigned StrbW = DataW / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } axi_aw_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } axi_ar_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } axi_w_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } axi_b_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
  } axi_r_t;

endpackage

module vlsu_axi_mem_sub
  import vlsu_axi_mem_sub_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned MemWords     = 1024,
  parameter logic [AxiAddrWidth-1:0] BaseAddr = '0,
  parameter int unsigned BDelay       = 0,
  parameter type axi_aw_t = vlsu_axi_mem_sub_pkg::axi_aw_t,
  parameter type axi_w_t  = vlsu_axi_mem_sub_pkg::axi_w_t,
  parameter type axi_b_t  = vlsu_axi_mem_sub_pkg::axi_b_t,
  parameter type axi_ar_t = vlsu_axi_mem_sub_pkg::axi_ar_t,
  parameter type axi_r_t  = vlsu_axi_mem_sub_pkg::axi_r_t
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    aw_valid_i,
  output logic    aw_ready_o,
  input  axi_aw_t aw_i,
  input  logic    w_valid_i,
  output logic    w_ready_o,
  input  axi_w_t  w_i,
  output logic    b_valid_o,
  input  logic    b_ready_i,
  output axi_b_t  b_o,
  input  logic    ar_valid_i,
  output logic    ar_ready_o,
  input  axi_ar_t ar_i,
  output logic    r_valid_o,
  input  logic    r_ready_i,
  output axi_r_t  r_o
);

  localparam int unsigned NB   = AxiDataWidth / 8;
  localparam int          OffW = $clog2(NB);
  localparam int unsigned IdxW = $clog2(MemWords);
  localparam logic [AxiAddrWidth:0] WinBytes =
    (AxiAddrWidth+1)'(MemWords * NB);

  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef logic [IdxW-1:0]         idx_t;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_WAIT, W_RESP
  } wst_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } rst_e;

  logic [AxiDataWidth-1:0] mem [MemWords];

  function automatic logic in_win(addr_t a);
    addr_t off;
    off = a - BaseAddr;
    return {1'b0, off} < WinBytes;
  endfunction

  function automatic idx_t idx_of(addr_t a);
    addr_t off;
    off = a - BaseAddr;
    return idx_t'(off >> OffW);
  endfunction

  // INCR aligns down to the beat size before stepping
  function automatic addr_t next_addr(
    addr_t a, logic [2:0] size, logic [1:0] burst
  );
    addr_t stp;
    stp = addr_t'(1) << size;
    if (burst == BURST_INCR)
      return (a & ~(stp - addr_t'(1))) + stp;
    return a;
  endfunction

  function automatic logic beat_ok(
    logic [2:0] size, logic [1:0] burst
  );
    return (burst != BURST_WRAP) && (int'(size) <= OffW);
  endfunction

  // ---------------- write path ----------------
  wst_e       wst, wst_nxt;
  logic [3:0] w_id;
  addr_t      w_addr;
  logic [7:0] w_len;
  logic [2:0] w_size;
  logic [1:0] w_burst;
  logic [7:0] w_cnt;
  logic       w_dec;
  logic       w_slv;
  logic [3:0] dly_cnt;

  logic aw_hs, w_hs, w_end, w_we;
  logic w_bad_last;
  idx_t w_idx;

  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_hs       = w_valid_i && w_ready_o;
  assign w_end      = w_hs && (w_cnt == w_len);
  assign w_bad_last = w_i.last != (w_cnt == w_len);
  assign w_idx      = idx_of(w_addr);
  assign w_we       = w_hs && in_win(w_addr)
                   && beat_ok(w_size, w_burst);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wst <= W_IDLE;
    else         wst <= wst_nxt;
  end

  always_comb begin
    wst_nxt = wst;
    unique case (wst)
      W_IDLE: if (aw_hs) wst_nxt = W_DATA;
      W_DATA: begin
        if (w_end)
          wst_nxt = (BDelay > 0) ? W_WAIT : W_RESP;
      end
      W_WAIT: begin
        if (dly_cnt == 4'(BDelay - 1))
          wst_nxt = W_RESP;
      end
      W_RESP: if (b_ready_i) wst_nxt = W_IDLE;
      default: wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o = (wst == W_IDLE);
    w_ready_o  = (wst == W_DATA);
    b_valid_o  = (wst == W_RESP);
    b_o        = '0;
    if (wst == W_RESP) begin
      b_o.id = w_id;
      unique case (1'b1)
        w_dec:   b_o.resp = RESP_DECERR;
        w_slv:   b_o.resp = RESP_SLVERR;
        default: b_o.resp = RESP_OKAY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_dec   <= 1'b0;
      w_slv   <= 1'b0;
      dly_cnt <= '0;
    end else begin
      if (aw_hs) begin
        w_id    <= aw_i.id;
        w_addr  <= aw_i.addr;
        w_len   <= aw_i.len;
        w_size  <= aw_i.size;
        w_burst <= aw_i.burst;
        w_cnt   <= '0;
        w_dec   <= 1'b0;
        w_slv   <= 1'b0;
      end
      if (w_hs) begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= next_addr(w_addr, w_size, w_burst);
        if (!in_win(w_addr))
          w_dec <= 1'b1;
        if (!beat_ok(w_size, w_burst) || w_bad_last)
          w_slv <= 1'b1;
      end
      if (wst == W_WAIT) dly_cnt <= dly_cnt + 4'd1;
      else               dly_cnt <= '0;
    end
  end

  // Array is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (w_i.strb[b])
          mem[w_idx][b*8 +: 8] <= w_i.data[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rst_e       rst, rst_nxt;
  logic [3:0] r_id;
  addr_t      r_addr;
  logic [7:0] r_len;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic [7:0] r_cnt;

  logic ar_hs, r_hs, r_last;
  idx_t r_idx;

  assign ar_hs  = ar_valid_i && ar_ready_o;
  assign r_hs   = r_valid_o && r_ready_i;
  assign r_last = (r_cnt == r_len);
  assign r_idx  = idx_of(r_addr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst <= R_IDLE;
    else         rst <= rst_nxt;
  end

  always_comb begin
    rst_nxt = rst;
    unique case (rst)
      R_IDLE: if (ar_hs) rst_nxt = R_DATA;
      R_DATA: if (r_hs && r_last) rst_nxt = R_IDLE;
      default: rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o = (rst == R_IDLE);
    r_valid_o  = (rst == R_DATA);
    r_o        = '0;
    if (rst == R_DATA) begin
      r_o.id   = r_id;
      r_o.last = r_last;
      unique case (1'b1)
        !in_win(r_addr):          r_o.resp = RESP_DECERR;
        !beat_ok(r_size, r_burst): r_o.resp = RESP_SLVERR;
        default: begin
          r_o.resp = RESP_OKAY;
          r_o.data = mem[r_idx];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= ar_i.id;
        r_addr  <= ar_i.addr;
        r_len   <= ar_i.len;
        r_size  <= ar_i.size;
        r_burst <= ar_i.burst;
        r_cnt   <= '0;
      end
      if (r_hs) begin
        r_cnt  <= r_cnt + 8'd1;
        r_addr <= next_addr(r_addr, r_size, r_burst);
      end
    end
  end

endmodule

// File: tb/tb_vlsu_axi_mem_sub.sv
// Directed bench for vlsu_axi_mem_sub.
// Base 0x1000_0000, 1024 x 128-bit words, BDelay 4.
module tb_vlsu_axi_mem_sub;
  import vlsu_axi_mem_sub_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] WEND = BASE + 32'h4000;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    aw_valid = 1'b0, aw_ready;
  axi_aw_t aw = '0;
  logic    w_valid = 1'b0, w_ready;
  axi_w_t  w = '0;
  logic    b_valid, b_ready = 1'b0;
  axi_b_t  b;
  logic    ar_valid = 1'b0, ar_ready;
  axi_ar_t ar = '0;
  logic    r_valid, r_ready = 1'b0;
  axi_r_t  r;

  int errs = 0;
  int checks = 0;

  logic [127:0] d1 [4];
  axi_r_t prev_r;
  logic   stalled, wh;
  int     k;

  always #5 clk = ~clk;

  vlsu_axi_mem_sub #(
    .AxiDataWidth(128),
    .AxiAddrWidth(32),
    .MemWords(1024),
    .BaseAddr(BASE),
    .BDelay(4)
  ) u_dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .aw_valid_i(aw_valid),
    .aw_ready_o(aw_ready),
    .aw_i(aw),
    .w_valid_i(w_valid),
    .w_ready_o(w_ready),
    .w_i(w),
    .b_valid_o(b_valid),
    .b_ready_i(b_ready),
    .b_o(b),
    .ar_valid_i(ar_valid),
    .ar_ready_o(ar_ready),
    .ar_i(ar),
    .r_valid_o(r_valid),
    .r_ready_i(r_ready),
    .r_o(r)
  );

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    aw = '{id: id, addr: a, len: len, size: sz, burst: bu};
    aw_valid = 1'b1;
    for (int i = 0; i < 64 && !aw_ready; i++) step();
    check("aw_ready", 256'(aw_ready), 256'(1));
    step();
    aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    ar = '{id: id, addr: a, len: len, size: sz, burst: bu};
    ar_valid = 1'b1;
    for (int i = 0; i < 64 && !ar_ready; i++) step();
    check("ar_ready", 256'(ar_ready), 256'(1));
    step();
    ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [127:0] d, input logic [15:0] s,
                        input logic l);
    w = '{data: d, strb: s, last: l};
    w_valid = 1'b1;
    for (int i = 0; i < 64 && !w_ready; i++) step();
    check("w_ready", 256'(w_ready), 256'(1));
    step();
    w_valid = 1'b0;
  endtask

  task automatic recv_b(input string tag, input logic [3:0] id,
                        input logic [1:0] resp);
    b_ready = 1'b1;
    for (int i = 0; i < 64 && !b_valid; i++) step();
    check({tag, ".valid"}, 256'(b_valid), 256'(1));
    check({tag, ".id"}, 256'(b.id), 256'(id));
    check({tag, ".resp"}, 256'(b.resp), 256'(resp));
    step();
    b_ready = 1'b0;
  endtask

  task automatic recv_r(input string tag, input logic [3:0] id,
                        input logic [127:0] d, input logic [1:0] resp,
                        input logic l);
    r_ready = 1'b1;
    for (int i = 0; i < 64 && !r_valid; i++) step();
    check({tag, ".valid"}, 256'(r_valid), 256'(1));
    check({tag, ".id"}, 256'(r.id), 256'(id));
    check({tag, ".data"}, 256'(r.data), 256'(d));
    check({tag, ".resp"}, 256'(r.resp), 256'(resp));
    check({tag, ".last"}, 256'(r.last), 256'(l));
    step();
    r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++)
      d1[i] = {4{32'hC0DE_0000 | 32'(i)}};

    // reset state
    step();
    step();
    rst_n = 1'b1;
    check("rst_b_valid", 256'(b_valid), 256'(0));
    check("rst_r_valid", 256'(r_valid), 256'(0));
    check("rst_b_o", 256'(b), 256'(0));
    check("rst_r_o", 256'(r), 256'(0));
    check("rst_w_ready", 256'(w_ready), 256'(0));
    step();
    check("rst_aw_ready", 256'(aw_ready), 256'(1));
    check("rst_ar_ready", 256'(ar_ready), 256'(1));

    // 1: INCR write then read back
    send_aw(4'd3, BASE + 32'h20, 8'd3, 3'd4, BURST_INCR);
    for (int i = 0; i < 4; i++)
      send_w(d1[i], 16'hFFFF, i == 3);
    recv_b("t1_b", 4'd3, RESP_OKAY);
    send_ar(4'd3, BASE + 32'h20, 8'd3, 3'd4, BURST_INCR);
    for (int i = 0; i < 4; i++)
      recv_r("t1_r", 4'd3, d1[i], RESP_OKAY, i == 3);

    // 2: partial strobe write
    send_aw(4'd1, BASE + 32'hA0, 8'd0, 3'd4, BURST_INCR);
    send_w({16{8'hAA}}, 16'hFFFF, 1'b1);
    recv_b("t2_b0", 4'd1, RESP_OKAY);
    send_aw(4'd1, BASE + 32'hA0, 8'd0, 3'd4, BURST_INCR);
    send_w(128'h0011223344556677_8899AABBCCDDEEFF, 16'h00FF, 1'b1);
    recv_b("t2_b1", 4'd1, RESP_OKAY);
    send_ar(4'd1, BASE + 32'hA0, 8'd0, 3'd4, BURST_INCR);
    recv_r("t2_r", 4'd1, 128'hAAAAAAAAAAAAAAAA_8899AABBCCDDEEFF,
           RESP_OKAY, 1'b1);

    // 3: B delay and B backpressure
    send_aw(4'd5, BASE + 32'h140, 8'd0, 3'd4, BURST_INCR);
    send_w(128'h5555, 16'hFFFF, 1'b1);
    check("t3_bv_t1", 256'(b_valid), 256'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_bv_early", 256'(b_valid), 256'(0));
    end
    step();
    check("t3_bv_t5", 256'(b_valid), 256'(1));
    aw = '{id: 4'd6, addr: BASE + 32'h150, len: 8'd0,
           size: 3'd4, burst: BURST_INCR};
    aw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_bv", 256'(b_valid), 256'(1));
      check("t3_stall_bo", 256'(b), 256'({4'd5, RESP_OKAY}));
      check("t3_stall_awr", 256'(aw_ready), 256'(0));
      step();
    end
    b_ready = 1'b1;
    check("t3_awr_hs", 256'(aw_ready), 256'(0));
    step();
    b_ready = 1'b0;
    check("t3_awr_after", 256'(aw_ready), 256'(1));
    step();
    aw_valid = 1'b0;
    send_w(128'h6666, 16'hFFFF, 1'b1);
    recv_b("t3_b6", 4'd6, RESP_OKAY);

    // 4: bursts straddling the window end
    send_aw(4'd7, WEND - 32'h10, 8'd1, 3'd4, BURST_INCR);
    send_w(128'h4A4A, 16'hFFFF, 1'b0);
    send_w(128'h4B4B, 16'hFFFF, 1'b1);
    recv_b("t4_b", 4'd7, RESP_DECERR);
    send_ar(4'd7, WEND - 32'h10, 8'd1, 3'd4, BURST_INCR);
    recv_r("t4_r0", 4'd7, 128'h4A4A, RESP_OKAY, 1'b0);
    recv_r("t4_r1", 4'd7, 128'h0, RESP_DECERR, 1'b1);

    // 5: WRAP, early last, oversize
    send_aw(4'd1, BASE + 32'h20, 8'd3, 3'd4, BURST_WRAP);
    for (int i = 0; i < 4; i++)
      send_w({4{32'hDEAD_BEEF}}, 16'hFFFF, i == 3);
    recv_b("t5_wrap_b", 4'd1, RESP_SLVERR);
    send_ar(4'd1, BASE + 32'h20, 8'd1, 3'd4, BURST_INCR);
    recv_r("t5_keep0", 4'd1, d1[0], RESP_OKAY, 1'b0);
    recv_r("t5_keep1", 4'd1, d1[1], RESP_OKAY, 1'b1);
    send_aw(4'd2, BASE + 32'h1E0, 8'd3, 3'd4, BURST_INCR);
    for (int i = 0; i < 4; i++)
      send_w(128'h77, 16'hFFFF, i == 2);
    recv_b("t5_last_b", 4'd2, RESP_SLVERR);
    send_ar(4'd2, BASE + 32'h20, 8'd0, 3'd5, BURST_INCR);
    recv_r("t5_oversz", 4'd2, 128'h0, RESP_SLVERR, 1'b1);

    // 6: concurrent AR/AW, random r_ready, reset mid-read
    aw = '{id: 4'd9, addr: BASE + 32'h280, len: 8'd0,
           size: 3'd4, burst: BURST_INCR};
    ar = '{id: 4'd4, addr: BASE + 32'h20, len: 8'd3,
           size: 3'd4, burst: BURST_INCR};
    aw_valid = 1'b1;
    ar_valid = 1'b1;
    check("t6_awr", 256'(aw_ready), 256'(1));
    check("t6_arr", 256'(ar_ready), 256'(1));
    step();
    aw_valid = 1'b0;
    ar_valid = 1'b0;
    w = '{data: 128'h6C6C_0909, strb: 16'hFFFF, last: 1'b1};
    w_valid = 1'b1;
    k = 0;
    stalled = 1'b0;
    prev_r = '0;
    for (int c = 0; c < 4; c++) begin
      r_ready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (stalled)
        check("t6_stall_r", 256'(r), 256'(prev_r));
      if (r_valid && r_ready) begin
        check("t6_r_data", 256'(r.data), 256'(d1[k]));
        k++;
      end
      stalled = r_valid && !r_ready;
      prev_r = r;
      wh = w_valid && w_ready;
      step();
      if (wh) w_valid = 1'b0;
    end
    r_ready = 1'b0;
    w_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rv", 256'(r_valid), 256'(0));
    check("t6_rst_bv", 256'(b_valid), 256'(0));
    check("t6_rst_r", 256'(r), 256'(0));
    step();
    rst_n = 1'b1;
    step();
    check("t6_arr_after", 256'(ar_ready), 256'(1));
    check("t6_awr_after", 256'(aw_ready), 256'(1));
    check("t6_rv_after", 256'(r_valid), 256'(0));
    send_ar(4'd0, BASE + 32'h280, 8'd0, 3'd4, BURST_INCR);
    recv_r("t6_kept", 4'd0, 128'h6C6C_0909, RESP_OKAY, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
